// File: rtl/bf_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
// Requests are one word per asserted cycle; responses return in order and are never refused.
interface bf_fetch_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );
endinterface

// File: rtl/bf_fetch.sv
// Instruction fetch unit: in-order requests from a 16-bit PC into a prefetch FIFO,
// with branch redirect that flushes the FIFO and drops in-flight old-path responses.
module bf_fetch #(
   parameter int          DEPTH = 4,
   parameter logic [15:0] NOP   = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       branch_val,
   input  logic              branch_en,
   input  logic              stall,
   output logic [15:0]       ins_out,
   output logic [15:0]       pc_out,
   bf_fetch_if.master        imem
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] OCC_CAP = (CW + 1)'(DEPTH);

   logic [15:0]   pc_q;
   logic [15:0]   fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] inflight_q;
   logic [CW-1:0] discard_q;

   logic [CW:0]   occupancy;
   logic          issue;
   logic          pop;
   logic          push;
   logic [CW-1:0] issue_inc;
   logic [CW-1:0] valid_dec;
   logic [CW-1:0] push_inc;
   logic [CW-1:0] pop_dec;

   // Issue is gated by rst_n so the request line drops the instant reset asserts.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch can be inferred.
      occupancy = {1'b0, inflight_q} + {1'b0, count_q};
      issue     = 1'b0;
      pop       = 1'b0;
      push      = 1'b0;
      ins_out   = NOP;
      if (rst_n && (occupancy < OCC_CAP) && !branch_en) begin
         issue = 1'b1;
      end
      if ((count_q != '0) && !branch_en && !stall) begin
         pop     = 1'b1;
         ins_out = fifo_mem[rd_ptr_q];
      end
      // A response arriving in the branch cycle is old-path and is never stored.
      if (imem.imem_valid && (discard_q == '0) && !branch_en) begin
         push = 1'b1;
      end
   end

   assign issue_inc = {{(CW-1){1'b0}}, issue};
   assign valid_dec = {{(CW-1){1'b0}}, imem.imem_valid};
   assign push_inc  = {{(CW-1){1'b0}}, push};
   assign pop_dec   = {{(CW-1){1'b0}}, pop};

   assign imem.imem_req  = issue;
   assign imem.imem_addr = pc_q;
   assign pc_out         = pc_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         inflight_q <= inflight_q + issue_inc - valid_dec;
         if (branch_en) begin
            // Everything still outstanding after this edge belongs to the old path.
            pc_q      <= branch_val;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            discard_q <= inflight_q - valid_dec;
         end else begin
            if (issue) begin
               pc_q <= pc_q + 16'd1;
            end
            if (imem.imem_valid && (discard_q != '0)) begin
               discard_q <= discard_q - 1'b1;
            end
            if (push) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + push_inc - pop_dec;
         end
      end
   end

   // NOTE: FIFO storage is not reset; count_q gates every read, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= imem.imem_rdata;
      end
   end

endmodule
